// File: rtl/mem_stage_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage data memory access controller.
//   state_e            : access FSM states (StIdle = 0, StWait = 1)
//   DEFAULT_BASE_ADDR  : byte address of data memory word 0
//   mem_wb_ctrl_t      : MEM/WB control fields
//   mem_wb_data_t      : MEM/WB data fields
//   *_BUBBLE           : MEM/WB contents of a pipeline bubble (all zero)
//   word_aligned()     : true when a byte address is 32-bit aligned
package mem_stage_access_ctrl_pkg;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StWait = 1'b1
    } state_e;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;

    typedef struct packed {
        logic       mem_to_reg;
        logic       reg_write;
        logic [4:0] write_register;
    } mem_wb_ctrl_t;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] read_data;
    } mem_wb_data_t;

    localparam mem_wb_ctrl_t MEM_WB_CTRL_BUBBLE = '0;
    localparam mem_wb_data_t MEM_WB_DATA_BUBBLE = '0;

    function automatic logic word_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/mem_stage_access_ctrl_pipe_reg.sv
// Generic pipeline register slice used to build the MEM/WB fields.
//   clk    : rising-edge clock
//   reset  : synchronous, active-high; clears the slice to zero
//   en_i   : load enable
//   d_i    : next contents
//   q_o    : registered contents
module mem_stage_access_ctrl_pipe_reg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q_o <= '0;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/mem_stage_access_ctrl.sv
// MEM-stage access controller. Consumes the EX/MEM register outputs, runs lw/sw against a
// req/ack data memory with variable latency, stalls upstream while an access is outstanding
// and drives the registered MEM/WB fields.
//   clk, reset            : clock and synchronous active-high reset
//   mem_read_i/write_i    : EX/MEM load / store
//   mem_to_reg_i          : EX/MEM writeback-from-memory select
//   reg_write_i           : EX/MEM register file write
//   write_register_i      : EX/MEM destination register
//   alu_result_i          : EX/MEM byte address or ALU result
//   read_data_2_i         : EX/MEM store data
//   dmem_req_o/we_o       : memory request (held until ack or abort) / write strobe
//   dmem_addr_o/wdata_o   : word index / store data, stable for the whole request
//   dmem_ack_i/rdata_i    : memory completion / load data valid with the ack
//   stall_o               : hold PC, IF/ID, ID/EX and EX/MEM
//   mem_to_reg_o .. read_data_o : MEM/WB fields
//   addr_err_o            : 1-cycle pulse for misaligned, out-of-range or read+write access
//   bus_err_o             : 1-cycle pulse when an access is aborted on timeout
module mem_stage_access_ctrl
    import mem_stage_access_ctrl_pkg::*;
#(
    parameter int unsigned MEMORY_DEPTH   = 32,
    parameter logic [31:0] BASE_ADDR      = DEFAULT_BASE_ADDR,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            mem_read_i,
    input  logic                            mem_write_i,
    input  logic                            mem_to_reg_i,
    input  logic                            reg_write_i,
    input  logic [4:0]                      write_register_i,
    input  logic [31:0]                     alu_result_i,
    input  logic [31:0]                     read_data_2_i,
    output logic                            dmem_req_o,
    output logic                            dmem_we_o,
    output logic [$clog2(MEMORY_DEPTH)-1:0] dmem_addr_o,
    output logic [31:0]                     dmem_wdata_o,
    input  logic                            dmem_ack_i,
    input  logic [31:0]                     dmem_rdata_i,
    output logic                            stall_o,
    output logic                            mem_to_reg_o,
    output logic                            reg_write_o,
    output logic [4:0]                      write_register_o,
    output logic [31:0]                     alu_result_o,
    output logic [31:0]                     read_data_o,
    output logic                            addr_err_o,
    output logic                            bus_err_o
);

    localparam int unsigned AW            = $clog2(MEMORY_DEPTH);
    localparam logic [7:0]  TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    state_e        state_q, state_d;
    logic [7:0]    wait_cnt_q, wait_cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          addr_err_q, addr_err_d;
    logic          bus_err_q, bus_err_d;

    logic          access;
    logic          both_set;
    logic          in_range;
    logic          legal;
    logic [31:0]   offset;
    logic          bubble;
    logic          take_rdata;
    logic          stall;

    mem_wb_ctrl_t  mem_wb_ctrl_d, mem_wb_ctrl_q;
    mem_wb_data_t  mem_wb_data_d, mem_wb_data_q;

    // Address decode. The lower-bound test guards against the subtraction wrapping.
    assign access   = mem_read_i | mem_write_i;
    assign both_set = mem_read_i & mem_write_i;
    assign offset   = alu_result_i - BASE_ADDR;
    assign in_range = (alu_result_i >= BASE_ADDR) && ((offset >> 2) < MEMORY_DEPTH);
    assign legal    = word_aligned(alu_result_i) && in_range && !both_set;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        addr_err_d = 1'b0;
        bus_err_d  = 1'b0;
        stall      = 1'b0;
        bubble     = 1'b0;
        take_rdata = 1'b0;

        unique case (state_q)
            StIdle: begin
                // An ack arriving here belongs to no request and is ignored.
                if (access) begin
                    bubble = 1'b1;
                    if (legal) begin
                        stall      = 1'b1;
                        state_d    = StWait;
                        wait_cnt_d = '0;
                        addr_d     = offset[AW+1:2];
                        we_d       = mem_write_i;
                        wdata_d    = read_data_2_i;
                    end else begin
                        addr_err_d = 1'b1;
                    end
                end
            end
            StWait: begin
                // Ack wins over a timeout that expires in the same cycle.
                if (dmem_ack_i) begin
                    state_d    = StIdle;
                    take_rdata = 1'b1;
                end else if (wait_cnt_q == TIMEOUT_LIMIT) begin
                    state_d   = StIdle;
                    bus_err_d = 1'b1;
                    bubble    = 1'b1;
                end else begin
                    stall  = 1'b1;
                    bubble = 1'b1;
                    if (wait_cnt_q != 8'hFF) begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            addr_err_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            addr_err_q <= addr_err_d;
            bus_err_q  <= bus_err_d;
        end
    end

    // MEM/WB next contents: live EX/MEM fields (held by the stall while waiting), or a bubble.
    // Stores and non-memory instructions carry zero read data.
    always_comb begin
        mem_wb_ctrl_d = MEM_WB_CTRL_BUBBLE;
        mem_wb_data_d = MEM_WB_DATA_BUBBLE;
        if (!bubble) begin
            mem_wb_ctrl_d.mem_to_reg     = mem_to_reg_i;
            mem_wb_ctrl_d.reg_write      = reg_write_i;
            mem_wb_ctrl_d.write_register = write_register_i;
            mem_wb_data_d.alu_result     = alu_result_i;
            mem_wb_data_d.read_data      = (take_rdata && !we_q) ? dmem_rdata_i : 32'h0;
        end
    end

    mem_stage_access_ctrl_pipe_reg #(
        .WIDTH($bits(mem_wb_ctrl_t))
    ) u_mem_wb_ctrl (
        .clk  (clk),
        .reset(reset),
        .en_i (1'b1),
        .d_i  (mem_wb_ctrl_d),
        .q_o  (mem_wb_ctrl_q)
    );

    mem_stage_access_ctrl_pipe_reg #(
        .WIDTH($bits(mem_wb_data_t))
    ) u_mem_wb_data (
        .clk  (clk),
        .reset(reset),
        .en_i (1'b1),
        .d_i  (mem_wb_data_d),
        .q_o  (mem_wb_data_q)
    );

    assign dmem_req_o       = (state_q == StWait);
    assign dmem_we_o        = we_q;
    assign dmem_addr_o      = addr_q;
    assign dmem_wdata_o     = wdata_q;
    assign stall_o          = stall;
    assign mem_to_reg_o     = mem_wb_ctrl_q.mem_to_reg;
    assign reg_write_o      = mem_wb_ctrl_q.reg_write;
    assign write_register_o = mem_wb_ctrl_q.write_register;
    assign alu_result_o     = mem_wb_data_q.alu_result;
    assign read_data_o      = mem_wb_data_q.read_data;
    assign addr_err_o       = addr_err_q;
    assign bus_err_o        = bus_err_q;

endmodule

// File: tb/tb_mem_stage_access_ctrl.sv
// Directed bench for mem_stage_access_ctrl: a transaction-level reference model checked every
// cycle, a latency-programmable memory responder, and hand-computed literal checks.
`timescale 1ns/1ps
module tb_mem_stage_access_ctrl;

    localparam logic [31:0] BASE  = 32'h1001_0000;
    localparam int          DEPTH = 32;
    localparam int          TMO   = 255;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read_i, mem_write_i, mem_to_reg_i, reg_write_i;
    logic [4:0]  write_register_i;
    logic [31:0] alu_result_i, read_data_2_i;
    logic        dmem_req_o, dmem_we_o;
    logic [4:0]  dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_ack_i;
    logic [31:0] dmem_rdata_i;
    logic        stall_o, mem_to_reg_o, reg_write_o;
    logic [4:0]  write_register_o;
    logic [31:0] alu_result_o, read_data_o;
    logic        addr_err_o, bus_err_o;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_stage_access_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .mem_read_i      (mem_read_i),
        .mem_write_i     (mem_write_i),
        .mem_to_reg_i    (mem_to_reg_i),
        .reg_write_i     (reg_write_i),
        .write_register_i(write_register_i),
        .alu_result_i    (alu_result_i),
        .read_data_2_i   (read_data_2_i),
        .dmem_req_o      (dmem_req_o),
        .dmem_we_o       (dmem_we_o),
        .dmem_addr_o     (dmem_addr_o),
        .dmem_wdata_o    (dmem_wdata_o),
        .dmem_ack_i      (dmem_ack_i),
        .dmem_rdata_i    (dmem_rdata_i),
        .stall_o         (stall_o),
        .mem_to_reg_o    (mem_to_reg_o),
        .reg_write_o     (reg_write_o),
        .write_register_o(write_register_o),
        .alu_result_o    (alu_result_o),
        .read_data_o     (read_data_o),
        .addr_err_o      (addr_err_o),
        .bus_err_o       (bus_err_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory responder: acks in the ack_lat-th request cycle (0 = never).
    int          ack_lat    = 0;
    int          req_age    = 0;
    int          req_starts = 0;
    logic [31:0] rdata_val  = 32'h0;
    logic        resp_ack   = 1'b0;
    logic        stray_ack  = 1'b0;

    assign dmem_ack_i   = resp_ack | stray_ack;
    assign dmem_rdata_i = resp_ack ? rdata_val : 32'h0BAD_F00D;

    always @(posedge clk) begin
        #1;
        if (dmem_req_o === 1'b1) begin
            if (req_age == 0) req_starts++;
            req_age++;
            resp_ack = (ack_lat != 0) && (req_age == ack_lat);
        end else begin
            req_age  = 0;
            resp_ack = 1'b0;
        end
    end

    // Reference model: one outstanding access record plus the registered MEM/WB view.
    typedef struct packed {
        bit          pend;
        int          waited;
        logic [4:0]  addr;
        logic        we;
        logic [31:0] wdata;
        logic        mtr;
        logic        rw;
        logic [4:0]  wreg;
        logic [31:0] alu;
        logic [31:0] rd;
        logic        aerr;
        logic        berr;
    } model_t;

    model_t m = '0;
    model_t n = '0;
    bit     armed = 1'b0;

    function automatic model_t bubbled(input model_t x);
        model_t y = x;
        y.mtr  = 1'b0;
        y.rw   = 1'b0;
        y.wreg = '0;
        y.alu  = '0;
        y.rd   = '0;
        return y;
    endfunction

    always @(negedge clk) begin
        bit acc;
        bit leg;
        bit exp_stall;
        acc = mem_read_i || mem_write_i;
        leg = (alu_result_i % 4 == 0) && (alu_result_i >= BASE)
              && ((alu_result_i - BASE) / 4 < DEPTH) && !(mem_read_i && mem_write_i);
        exp_stall = m.pend ? (!dmem_ack_i && m.waited < TMO) : (acc && leg);

        if (armed) begin
            check("stall_o", stall_o, exp_stall);
            check("dmem_req_o", dmem_req_o, m.pend);
            check("dmem_we_o", dmem_we_o, m.we);
            check("dmem_addr_o", dmem_addr_o, m.addr);
            check("dmem_wdata_o", dmem_wdata_o, m.wdata);
            check("mem_to_reg_o", mem_to_reg_o, m.mtr);
            check("reg_write_o", reg_write_o, m.rw);
            check("write_register_o", write_register_o, m.wreg);
            check("alu_result_o", alu_result_o, m.alu);
            check("read_data_o", read_data_o, m.rd);
            check("addr_err_o", addr_err_o, m.aerr);
            check("bus_err_o", bus_err_o, m.berr);
        end

        n      = m;
        n.aerr = 1'b0;
        n.berr = 1'b0;
        if (reset) begin
            n = '0;
        end else if (!m.pend) begin
            if (acc && leg) begin
                n        = bubbled(n);
                n.pend   = 1'b1;
                n.waited = 0;
                n.addr   = 5'((alu_result_i - BASE) >> 2);
                n.we     = mem_write_i;
                n.wdata  = read_data_2_i;
            end else if (acc) begin
                n      = bubbled(n);
                n.aerr = 1'b1;
            end else begin
                n.mtr  = mem_to_reg_i;
                n.rw   = reg_write_i;
                n.wreg = write_register_i;
                n.alu  = alu_result_i;
                n.rd   = 32'h0;
            end
        end else if (dmem_ack_i) begin
            n.pend = 1'b0;
            n.mtr  = mem_to_reg_i;
            n.rw   = reg_write_i;
            n.wreg = write_register_i;
            n.alu  = alu_result_i;
            n.rd   = m.we ? 32'h0 : dmem_rdata_i;
        end else if (m.waited == TMO) begin
            n      = bubbled(n);
            n.pend = 1'b0;
            n.berr = 1'b1;
        end else begin
            n        = bubbled(n);
            n.waited = m.waited + 1;
        end
    end

    always @(posedge clk) begin
        m <= n;
        if (reset) armed <= 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic mtr, input logic rw,
                         input logic [4:0] wreg, input logic [31:0] alu, input logic [31:0] wd);
        mem_read_i       = rd;
        mem_write_i      = wr;
        mem_to_reg_i     = mtr;
        reg_write_i      = rw;
        write_register_i = wreg;
        alu_result_i     = alu;
        read_data_2_i    = wd;
    endtask

    task automatic idle_inputs();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    endtask

    // Present one memory instruction, hold it while stalled (bounded), count stall cycles,
    // then step past the completing edge with idle inputs.
    task automatic run_mem(input logic rd, input logic wr, input logic [4:0] wreg,
                           input logic [31:0] alu, input logic [31:0] wd, input int lat,
                           output int stalls);
        ack_lat = lat;
        drive(rd, wr, rd, rd, wreg, alu, wd);
        stalls = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (stall_o !== 1'b1) break;
            stalls++;
        end
        tick();
        idle_inputs();
    endtask

    int stalls;
    int stalls2;
    int starts0;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("reset stall", stall_o, 0);
        check("reset req", dmem_req_o, 0);
        check("reset reg_write", reg_write_o, 0);

        // Plain ALU op: one-cycle pass-through, never stalls.
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h0000_0007, 32'h0);
        @(negedge clk);
        check("alu stall", stall_o, 0);
        tick();
        idle_inputs();
        @(negedge clk);
        check("alu result", alu_result_o, 32'h7);
        check("alu reg_write", reg_write_o, 1);
        check("alu wreg", write_register_o, 5);

        // lw with immediate ack.
        tick();
        rdata_val = 32'hDEAD_BEEF;
        run_mem(1'b1, 1'b0, 5'd8, 32'h1001_0008, 32'h0, 1, stalls);
        check("lw stalls", stalls, 1);
        @(negedge clk);
        check("lw addr", dmem_addr_o, 2);
        check("lw rdata", read_data_o, 32'hDEAD_BEEF);
        check("lw reg_write", reg_write_o, 1);
        check("lw we", dmem_we_o, 0);

        // sw to the last word, ack in the 3rd wait cycle.
        tick();
        run_mem(1'b0, 1'b1, 5'd0, 32'h1001_007C, 32'h1234_5678, 3, stalls);
        check("sw stalls", stalls, 3);
        @(negedge clk);
        check("sw we", dmem_we_o, 1);
        check("sw addr", dmem_addr_o, 31);
        check("sw wdata", dmem_wdata_o, 32'h1234_5678);
        check("sw reg_write", reg_write_o, 0);
        check("sw read_data", read_data_o, 0);

        // Illegal accesses: misaligned, past the end, read+write, below base.
        tick();
        starts0 = req_starts;
        drive(1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 32'h1001_0006, 32'h0);
        @(negedge clk);
        check("misaligned stall", stall_o, 0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 32'h1001_0080, 32'h0);
        @(negedge clk);
        check("misaligned addr_err", addr_err_o, 1);
        check("oor stall", stall_o, 0);
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 5'd9, 32'h1001_0010, 32'h0);
        @(negedge clk);
        check("oor addr_err", addr_err_o, 1);
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 32'h1000_FFFC, 32'h0);
        @(negedge clk);
        check("rw both addr_err", addr_err_o, 1);
        tick();
        idle_inputs();
        @(negedge clk);
        check("below base addr_err", addr_err_o, 1);
        check("illegal reg_write", reg_write_o, 0);
        tick();
        @(negedge clk);
        check("addr_err cleared", addr_err_o, 0);
        check("illegal no req", req_starts - starts0, 0);

        // Timeout: no ack ever.
        tick();
        run_mem(1'b1, 1'b0, 5'd10, 32'h1001_0000, 32'h0, 0, stalls);
        check("timeout stalls", stalls, 256);
        @(negedge clk);
        check("timeout bus_err", bus_err_o, 1);
        check("timeout req", dmem_req_o, 0);
        check("timeout stall", stall_o, 0);
        check("timeout reg_write", reg_write_o, 0);
        tick();
        @(negedge clk);
        check("bus_err cleared", bus_err_o, 0);

        // Back-to-back loads: each gets its own request.
        tick();
        starts0   = req_starts;
        rdata_val = 32'hA5A5_0001;
        run_mem(1'b1, 1'b0, 5'd3, 32'h1001_0004, 32'h0, 1, stalls);
        rdata_val = 32'h5A5A_0002;
        run_mem(1'b1, 1'b0, 5'd4, 32'h1001_0078, 32'h0, 2, stalls2);
        check("b2b stalls 1", stalls, 1);
        check("b2b stalls 2", stalls2, 2);
        @(negedge clk);
        check("b2b rdata 2", read_data_o, 32'h5A5A_0002);
        check("b2b wreg 2", write_register_o, 4);
        check("b2b addr 2", dmem_addr_o, 30);
        check("b2b req count", req_starts - starts0, 2);

        // Stray ack while idle.
        tick();
        stray_ack = 1'b1;
        @(negedge clk);
        check("stray req", dmem_req_o, 0);
        check("stray stall", stall_o, 0);
        tick();
        stray_ack = 1'b0;
        @(negedge clk);
        check("stray read_data", read_data_o, 0);

        // Reset in the 2nd wait cycle, then a late ack.
        tick();
        ack_lat = 0;
        drive(1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 32'h1001_0020, 32'h0);
        tick();
        tick();
        reset = 1'b1;
        idle_inputs();
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("rst req", dmem_req_o, 0);
        check("rst stall", stall_o, 0);
        check("rst addr", dmem_addr_o, 0);
        check("rst reg_write", reg_write_o, 0);
        check("rst alu_result", alu_result_o, 0);
        tick();
        stray_ack = 1'b1;
        @(negedge clk);
        check("late ack req", dmem_req_o, 0);
        check("late ack stall", stall_o, 0);
        tick();
        stray_ack = 1'b0;
        @(negedge clk);
        check("late ack read_data", read_data_o, 0);

        tick();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
